// File: rtl/scroll_pattern_engine.sv
// rtl/scroll_pattern_engine.sv - two-axis scrolling VGA test-pattern generator with ping-pong velocity
module scroll_pattern_engine #(
    parameter int COORD_W = 10,
    parameter int VEL_W   = 8,
    parameter int VMAX_X  = 20,
    parameter int VMIN_X  = -10,
    parameter int VMAX_Y  = 6,
    parameter int VMIN_Y  = -6,
    parameter int ACCEL   = 1,
    parameter int VS_POL  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vsync,
    input  logic                    display_on,
    input  logic [COORD_W-1:0]      pix_x,
    input  logic [COORD_W-1:0]      pix_y,
    input  logic [1:0]              mode,
    input  logic                    pause,
    input  logic                    y_en,
    output logic [1:0]              R,
    output logic [1:0]              G,
    output logic [1:0]              B,
    output logic                    frame_tick,
    output logic signed [VEL_W-1:0] vel_x
);

    localparam logic VS_ACT = (VS_POL != 0);

    localparam logic signed [VEL_W:0] VMAX_XE = (VEL_W+1)'(VMAX_X);
    localparam logic signed [VEL_W:0] VMIN_XE = (VEL_W+1)'(VMIN_X);
    localparam logic signed [VEL_W:0] VMAX_YE = (VEL_W+1)'(VMAX_Y);
    localparam logic signed [VEL_W:0] VMIN_YE = (VEL_W+1)'(VMIN_Y);
    localparam logic signed [VEL_W:0] ACCEL_E = (VEL_W+1)'(ACCEL);

    logic                    vs_q;
    logic                    tick_q, tick_d;
    logic [1:0]              mode_q;
    logic [COORD_W-1:0]      off_x_q, off_x_d, off_y_q, off_y_d;
    logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic                    dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [1:0]              r_q, g_q, b_q, r_d, g_d, b_d;

    // Returns {next_dir, next_vel}; one extra bit of headroom keeps the turn-point compare from overflowing.
    function automatic logic [VEL_W:0] vel_step(input logic signed [VEL_W-1:0] v,
                                                input logic dir,
                                                input logic signed [VEL_W:0] vmax,
                                                input logic signed [VEL_W:0] vmin);
        logic signed [VEL_W:0] ve;
        logic signed [VEL_W:0] nv;
        ve = (VEL_W+1)'(v);
        if (!dir) begin
            nv = ve + ACCEL_E;
            if (nv >= vmax) vel_step = {1'b1, vmax[VEL_W-1:0]};
            else            vel_step = {1'b0, nv[VEL_W-1:0]};
        end else begin
            nv = ve - ACCEL_E;
            if (nv <= vmin) vel_step = {1'b0, vmin[VEL_W-1:0]};
            else            vel_step = {1'b1, nv[VEL_W-1:0]};
        end
    endfunction

    assign tick_d = (vsync == VS_ACT) && (vs_q != VS_ACT);

    always_comb begin
        off_x_d = off_x_q;
        vel_x_d = vel_x_q;
        dir_x_d = dir_x_q;
        off_y_d = off_y_q;
        vel_y_d = vel_y_q;
        dir_y_d = dir_y_q;
        if (tick_q && !pause) begin
            off_x_d            = off_x_q + COORD_W'(vel_x_q);
            {dir_x_d, vel_x_d} = vel_step(vel_x_q, dir_x_q, VMAX_XE, VMIN_XE);
            if (y_en) begin
                off_y_d            = off_y_q + COORD_W'(vel_y_q);
                {dir_y_d, vel_y_d} = vel_step(vel_y_q, dir_y_q, VMAX_YE, VMIN_YE);
            end
        end
    end

    logic [COORD_W-1:0] mx, my;
    logic [3:0]         d_hi;
    logic               chk;

    assign mx   = pix_x + off_x_q;
    assign my   = pix_y + off_y_q;
    assign d_hi = 4'((mx + my) >> 5);
    assign chk  = mx[5] ^ my[5];

    always_comb begin
        r_d = 2'b00;
        g_d = 2'b00;
        b_d = 2'b00;
        if (display_on) begin
            unique case (mode_q)
                2'd0: begin
                    r_d = {mx[5], my[2]};
                    g_d = {mx[6], my[2]};
                    b_d = {mx[7], my[5]};
                end
                2'd1: begin
                    r_d = {chk, chk};
                    g_d = {chk, chk};
                    b_d = {chk, chk};
                end
                2'd2: begin
                    r_d = d_hi[1:0];
                    g_d = d_hi[2:1];
                    b_d = d_hi[3:2];
                end
                default: begin
                    r_d = {2{mx[7]}};
                    g_d = my[7:6];
                    b_d = 2'b01;
                end
            endcase
        end
    end

    // vs_q resets to the active level so a vsync already asserted at release cannot fire a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= VS_ACT;
            tick_q  <= 1'b0;
            mode_q  <= 2'd0;
            off_x_q <= '0;
            off_y_q <= '0;
            vel_x_q <= '0;
            vel_y_q <= '0;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
            r_q     <= 2'b00;
            g_q     <= 2'b00;
            b_q     <= 2'b00;
        end else begin
            vs_q    <= vsync;
            tick_q  <= tick_d;
            if (tick_q) mode_q <= mode;
            off_x_q <= off_x_d;
            off_y_q <= off_y_d;
            vel_x_q <= vel_x_d;
            vel_y_q <= vel_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign R          = r_q;
    assign G          = g_q;
    assign B          = b_q;
    assign frame_tick = tick_q;
    assign vel_x      = vel_x_q;

endmodule

// File: tb/tb_scroll_pattern_engine.sv
// tb/tb_scroll_pattern_engine.sv - directed self-checking bench for scroll_pattern_engine
module tb_scroll_pattern_engine;

    logic              clk;
    logic              rst_n;
    logic              vsync;
    logic              display_on;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic [1:0]        mode;
    logic              pause;
    logic              y_en;
    logic [1:0]        R, G, B;
    logic              frame_tick;
    logic signed [7:0] vel_x;

    int checks = 0;
    int errors = 0;

    scroll_pattern_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .display_on (display_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .mode       (mode),
        .pause      (pause),
        .y_en       (y_en),
        .R          (R),
        .G          (G),
        .B          (B),
        .frame_tick (frame_tick),
        .vel_x      (vel_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        vsync      = 1'b0;
        display_on = 1'b0;
        pix_x      = '0;
        pix_y      = '0;
        mode       = 2'd0;
        pause      = 1'b0;
        y_en       = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_frame(output int ticks);
        ticks = 0;
        vsync = 1'b1;
        repeat (4) begin
            step();
            if (frame_tick === 1'b1) ticks++;
        end
        vsync = 1'b0;
        repeat (3) begin
            step();
            if (frame_tick === 1'b1) ticks++;
        end
    endtask

    task automatic drive_pix(input logic [9:0] x, input logic [9:0] y);
        pix_x      = x;
        pix_y      = y;
        display_on = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({R, G, B, frame_tick} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {R, G, B, frame_tick});
        end
        checks++;
        if (vel_x !== 8'sd0 || dut.off_x_q !== 10'd0) begin
            errors++;
            $display("FAIL reset_axis: vel_x %0d off_x %0d required 0 0", vel_x, dut.off_x_q);
        end
    endtask

    task automatic test_accel();
        int t;
        int exp_vel[3] = '{1, 2, 3};
        int exp_off[3] = '{0, 1, 3};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(t);
            checks++;
            if (t != 1) begin
                errors++;
                $display("FAIL accel_tick f%0d: got %0d pulses required 1", f + 1, t);
            end
            checks++;
            if (vel_x !== 8'(exp_vel[f]) || dut.off_x_q !== 10'(exp_off[f])) begin
                errors++;
                $display("FAIL accel_axis f%0d: vel %0d off %0d required %0d %0d",
                         f + 1, vel_x, dut.off_x_q, exp_vel[f], exp_off[f]);
            end
        end
    endtask

    task automatic test_ping_pong();
        int t;
        do_reset();
        for (int f = 1; f <= 51; f++) begin
            run_frame(t);
            if (f == 20) begin
                checks++;
                if (vel_x !== 8'sd20 || dut.off_x_q !== 10'd190) begin
                    errors++;
                    $display("FAIL pingpong_f20: vel %0d off %0d required 20 190", vel_x, dut.off_x_q);
                end
            end
            if (f == 21) begin
                checks++;
                if (vel_x !== 8'sd19) begin
                    errors++;
                    $display("FAIL pingpong_f21: vel %0d required 19", vel_x);
                end
            end
            if (f == 50) begin
                checks++;
                if (vel_x !== -8'sd10) begin
                    errors++;
                    $display("FAIL pingpong_f50: vel %0d required -10", vel_x);
                end
            end
            if (f == 51) begin
                checks++;
                if (vel_x !== -8'sd9) begin
                    errors++;
                    $display("FAIL pingpong_f51: vel %0d required -9", vel_x);
                end
            end
        end
    endtask

    task automatic test_pause();
        int t;
        int total;
        total = 0;
        do_reset();
        for (int f = 1; f <= 9; f++) begin
            pause = (f >= 5);
            run_frame(t);
            if (f >= 5) total += t;
        end
        pause = 1'b0;
        checks++;
        if (total != 5) begin
            errors++;
            $display("FAIL pause_ticks: got %0d required 5", total);
        end
        checks++;
        if (vel_x !== 8'sd4 || dut.off_x_q !== 10'd6) begin
            errors++;
            $display("FAIL pause_frozen: vel %0d off %0d required 4 6", vel_x, dut.off_x_q);
        end
    endtask

    task automatic test_stripes();
        do_reset();
        drive_pix(10'h0E0, 10'h024);
        checks++;
        if ({R, G, B} !== 6'b11_11_11) begin
            errors++;
            $display("FAIL stripes_a: got %b required 111111", {R, G, B});
        end
        drive_pix(10'h020, 10'h004);
        checks++;
        if ({R, G, B} !== 6'b11_01_00) begin
            errors++;
            $display("FAIL stripes_b: got %b required 110100", {R, G, B});
        end
    endtask

    task automatic test_mode_switch();
        int t;
        do_reset();
        mode = 2'd1;
        drive_pix(10'd32, 10'd0);
        checks++;
        if ({R, G, B} !== 6'b10_00_00) begin
            errors++;
            $display("FAIL mode_hold: got %b required 100000", {R, G, B});
        end
        display_on = 1'b0;
        run_frame(t);
        drive_pix(10'd32, 10'd0);
        checks++;
        if ({R, G, B} !== 6'b11_11_11) begin
            errors++;
            $display("FAIL checker: got %b required 111111", {R, G, B});
        end
    endtask

    task automatic test_diag_bars();
        int t;
        do_reset();
        mode = 2'd2;
        run_frame(t);
        drive_pix(10'h060, 10'h040);
        checks++;
        if ({R, G, B} !== 6'b01_10_01) begin
            errors++;
            $display("FAIL diagonal: got %b required 011001", {R, G, B});
        end
        do_reset();
        mode = 2'd3;
        run_frame(t);
        drive_pix(10'h080, 10'h0C0);
        checks++;
        if ({R, G, B} !== 6'b11_11_01) begin
            errors++;
            $display("FAIL bars_a: got %b required 111101", {R, G, B});
        end
        drive_pix(10'h000, 10'h040);
        checks++;
        if ({R, G, B} !== 6'b00_01_01) begin
            errors++;
            $display("FAIL bars_b: got %b required 000101", {R, G, B});
        end
        pix_x      = 10'h080;
        pix_y      = 10'h0C0;
        display_on = 1'b0;
        step();
        checks++;
        if ({R, G, B} !== 6'd0) begin
            errors++;
            $display("FAIL display_off: got %b required 0", {R, G, B});
        end
    endtask

    task automatic test_long_vsync();
        int t;
        t = 0;
        do_reset();
        vsync = 1'b1;
        repeat (1000) begin
            step();
            if (frame_tick === 1'b1) t++;
        end
        vsync = 1'b0;
        repeat (3) begin
            step();
            if (frame_tick === 1'b1) t++;
        end
        checks++;
        if (t != 1) begin
            errors++;
            $display("FAIL long_vsync: got %0d pulses required 1", t);
        end
    endtask

    task automatic test_y_axis();
        int t;
        do_reset();
        y_en = 1'b0;
        repeat (3) run_frame(t);
        checks++;
        if (dut.off_y_q !== 10'd0 || dut.off_x_q !== 10'd3) begin
            errors++;
            $display("FAIL y_hold: off_y %0d off_x %0d required 0 3", dut.off_y_q, dut.off_x_q);
        end
        y_en = 1'b1;
        repeat (3) run_frame(t);
        checks++;
        if (dut.off_y_q !== 10'd3) begin
            errors++;
            $display("FAIL y_scroll: off_y %0d required 3", dut.off_y_q);
        end
    endtask

    task automatic test_async_reset();
        int t;
        t = 0;
        do_reset();
        mode = 2'd3;
        repeat (3) run_frame(t);
        drive_pix(10'h080, 10'h0C0);
        checks++;
        if ({R, G, B} !== 6'b11_11_01) begin
            errors++;
            $display("FAIL pre_reset_bars: got %b required 111101", {R, G, B});
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({R, G, B, frame_tick} !== 7'd0 || vel_x !== 8'sd0 || dut.off_x_q !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: rgbt %b vel %0d off %0d required 0", {R, G, B, frame_tick},
                     vel_x, dut.off_x_q);
        end
        vsync = 1'b1;
        step();
        rst_n = 1'b1;
        t = 0;
        repeat (6) begin
            step();
            if (frame_tick === 1'b1) t++;
        end
        vsync = 1'b0;
        checks++;
        if (t != 0 || dut.off_x_q !== 10'd0) begin
            errors++;
            $display("FAIL post_reset: ticks %0d off %0d required 0 0", t, dut.off_x_q);
        end
    endtask

    initial begin
        test_reset();
        test_accel();
        test_ping_pong();
        test_pause();
        test_stripes();
        test_mode_switch();
        test_diag_bars();
        test_long_vsync();
        test_y_axis();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
